// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: N-stage valid/ready pipeline register; per-stage valid bits let bubbles collapse
module pipe_reg_hs #(
  parameter int S = 12,
  parameter int N = 3,
  localparam int W = $clog2(N + 1)
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic         FLUSH,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [S-1:0] D,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [S-1:0] Q,
  output logic [W-1:0] OCC
);
  logic [S-1:0] dat_q [N];
  logic [S-1:0] din   [N];
  logic [N-1:0] v_q, v_d, adv, ld;
  logic [W-1:0] occ_q, occ_d;
  logic         acc, cons;
  // ready ripples combinationally from OUT_READY back to stage 0
  always_comb begin
    logic a;
    a = v_q[N-1] & OUT_READY;
    adv = '0;
    adv[N-1] = a;
    for (int i = N - 2; i >= 0; i--) begin
      a = v_q[i] & (~v_q[i+1] | a);
      adv[i] = a;
    end
    IN_READY = ~v_q[0] | adv[0];
    acc = IN_VALID & IN_READY;
    cons = adv[N-1];
    ld = '0;
    ld[0] = acc;
    din[0] = D;
    for (int i = 1; i < N; i++) begin
      ld[i] = adv[i-1];
      din[i] = dat_q[i-1];
    end
    v_d = (v_q & ~adv) | ld;
    occ_d = (acc & ~cons) ? occ_q + W'(1) : (~acc & cons) ? occ_q - W'(1) : occ_q;
  end
  // flush clears valids only; data registers keep their stale contents
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      v_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < N; i++) dat_q[i] <= '0;
    end else begin
      v_q <= FLUSH ? '0 : v_d;
      occ_q <= FLUSH ? '0 : occ_d;
      for (int i = 0; i < N; i++) if (!FLUSH && ld[i]) dat_q[i] <= din[i];
    end
  end
  assign Q = dat_q[N-1];
  assign OUT_VALID = v_q[N-1];
  assign OCC = occ_q;
endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb_pipe_reg_hs: directed plus random checks of pipe_reg_hs against a slot-level reference model
module tb_pipe_reg_hs;
  localparam int S = 12;
  localparam int N = 3;
  localparam int W = $clog2(N + 1);
  logic         CLK = 0, CLR_N, FLUSH, IN_VALID, OUT_READY;
  logic [S-1:0] D;
  logic         IN_READY, OUT_VALID;
  logic [S-1:0] Q;
  logic [W-1:0] OCC;
  int           tests = 0, fails = 0;
  logic         m_v [N];
  logic [S-1:0] m_d [N];
  logic         last_acc;
  logic [S-1:0] w;

  pipe_reg_hs #(.S(S), .N(N)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D(D), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Q(Q), .OCC(OCC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int cnt_v();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_v[i]);
    return c;
  endfunction

  // a word moves forward whenever any slot ahead of it is free or the head is consumed
  task automatic cyc(input logic cn, input logic fl, input logic iv, input logic [S-1:0] d,
                     input logic orr);
    int           cnt;
    logic         cons, space;
    logic         nv [N];
    logic [S-1:0] nd [N];
    CLR_N = cn; FLUSH = fl; IN_VALID = iv; D = d; OUT_READY = orr;
    cnt = cnt_v();
    #1;
    chk("in_ready", 32'(IN_READY), 32'((cnt < N) || orr));
    @(posedge CLK);
    cons = m_v[N-1] && orr;
    last_acc = cn && !fl && iv && ((cnt < N) || orr);
    if (!cn) begin
      for (int i = 0; i < N; i++) begin m_v[i] = 0; m_d[i] = '0; end
    end else if (fl) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin nv[i] = 0; nd[i] = m_d[i]; end
      for (int i = 0; i < N - 1; i++) if (m_v[i]) begin
        space = cons;
        for (int j = i + 1; j < N; j++) if (!m_v[j]) space = 1;
        if (space) begin nv[i+1] = 1; nd[i+1] = m_d[i]; end
        else nv[i] = 1;
      end
      if (m_v[N-1] && !cons) nv[N-1] = 1;
      if (last_acc) begin nv[0] = 1; nd[0] = d; end
      for (int i = 0; i < N; i++) begin m_v[i] = nv[i]; m_d[i] = nd[i]; end
    end
    #1;
    chk("out_valid", 32'(OUT_VALID), 32'(m_v[N-1]));
    chk("q", 32'(Q), 32'(m_d[N-1]));
    chk("occ", 32'(OCC), 32'(cnt_v()));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_d[i] = '0; end
    CLR_N = 0; FLUSH = 0; IN_VALID = 1; D = 12'hABC; OUT_READY = 0;
    @(posedge CLK); #1;
    cyc(0, 0, 1, 12'hABC, 0);
    cyc(0, 0, 1, 12'hABC, 0);
    chk("rst_q", 32'(Q), 0);
    chk("rst_ov", 32'(OUT_VALID), 0);
    chk("rst_occ", 32'(OCC), 0);
    chk("rst_ir", 32'(IN_READY), 1);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 1, S'(k), 1);
      if (k == 2) chk("lat_not_yet", 32'(OUT_VALID), 0);
      if (k == 3) chk("lat_first", 32'(Q), 1);
      if (k >= 4) chk("steady_occ", 32'(OCC), 3);
    end
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, '0, 1);
    chk("drained", 32'(OCC), 0);
    w = 12'h010;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1, w, 0);
      if (last_acc) w++;
    end
    chk("bp_next", 32'(w), 32'h013);
    chk("bp_occ", 32'(OCC), 3);
    chk("bp_q", 32'(Q), 32'h010);
    chk("bp_ir", 32'(IN_READY), 0);
    cyc(1, 0, 1, w, 1);
    chk("bp_acc", 32'(last_acc), 1);
    chk("bp_occ2", 32'(OCC), 3);
    chk("bp_q2", 32'(Q), 32'h011);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, '0, 1);
    cyc(1, 0, 1, 12'h021, 0);
    cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 1, 12'h022, 0);
    cyc(1, 0, 0, '0, 0);
    chk("bub_occ", 32'(OCC), 2);
    chk("bub_q", 32'(Q), 32'h021);
    chk("bub_ir", 32'(IN_READY), 1);
    cyc(1, 0, 1, 12'h030, 0);
    chk("fill_occ", 32'(OCC), 3);
    cyc(1, 1, 1, 12'h0FF, 0);
    chk("fl_occ", 32'(OCC), 0);
    chk("fl_ov", 32'(OUT_VALID), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, '0, 1);
      chk("fl_no_ff", 32'(Q == 12'h0FF), 0);
    end
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S'(12'h040 + k), 0);
    cyc(0, 1, 1, 12'h5A5, 1);
    chk("rstfl_q", 32'(Q), 0);
    chk("rstfl_occ", 32'(OCC), 0);
    for (int k = 0; k < 1000; k++)
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0, 1'($urandom),
          S'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_reg_hs.md
# pipe_reg_hs

- Parametrised pipeline register: a chain of N data stages, each S bits wide, with a valid/ready handshake on both sides.
- Each stage carries its own valid bit:
  - Bubbles collapse, so an empty stage accepts data even while the output stalls.
  - A full, unstalled pipe sustains one word per cycle.
- Successor to the single-stage clearable data register; used wherever datapath words must be delayed or retimed without losing back-pressure.

## Interface
Parameters:
- S, 12: data word width in bits (≥1).
- N, 3: number of pipeline stages (≥1).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- CLR_N  in  1  synchronous active-low reset, sampled on rising CLK.
- FLUSH  in  1  synchronous clear of all stage valid bits.
- IN_VALID  in  1  D holds a word to accept.
- IN_READY  out  1  pipe can accept D this cycle.
- D  in  S  input data word.
- OUT_VALID  out  1  Q holds a valid word.
- OUT_READY  in  1  downstream consumes Q this cycle.
- Q  out  S  output data word (stage N-1 data register).
- OCC  out  $clog2(N+1)  number of valid stages, 0..N.

## Operation
Stage state:
- Stages 0..N-1, each with data register dat[i] (S bits) and valid bit v[i].
- Stage 0 is the input side; stage N-1 drives Q and OUT_VALID.

Advance rules (combinational, evaluated each cycle):
- adv[N-1] = v[N-1] & OUT_READY.
- For i<N-1: adv[i] = v[i] & (~v[i+1] | adv[i+1]).
- IN_READY = ~v[0] | adv[0]. The chain is combinational from OUT_READY to IN_READY; no registered ready.

Stage update at rising CLK, when CLR_N=1 and FLUSH=0:
- For i≥1:
  - If adv[i-1]: dat[i]<=dat[i-1], v[i]<=1.
  - Else if adv[i]: v[i]<=0.
  - Else: hold.
- Stage 0:
  - If IN_VALID & IN_READY: dat[0]<=D, v[0]<=1.
  - Else if adv[0]: v[0]<=0.
  - Else: hold.
- Data registers load only on advance. A stage whose valid bit is clear keeps stale data.

Other behaviour:
- OCC is a registered counter: +1 on accept, −1 on output consume, unchanged when both or neither occur. It must always equal popcount(v).
- FLUSH=1 (and CLR_N=1):
  - All v<=0 and OCC<=0.
  - Data registers hold.
  - The input handshake in that cycle is discarded, even though IN_READY may be 1.
- CLR_N=0 (priority over FLUSH and all handshakes):
  - All v<=0, all dat<=0, OCC<=0.
  - Q=0, OUT_VALID=0; IN_READY=1 after reset.
- N=1 degenerates to a single register stage with pass-through ready: IN_READY = ~v[0] | OUT_READY.

## Timing
- Reset values:
  - OUT_VALID=0, Q=0, OCC=0.
  - IN_READY=1 (combinational from empty state).
- Latency: a word accepted at edge k appears on Q with OUT_VALID=1 after edge k+N−1, i.e. N cycles from D sampled to Q, when no stall occurs.
- Throughput: 1 word/cycle when OUT_READY=1 continuously.
- Stall: with OUT_READY=0, the pipe keeps accepting until OCC=N. IN_READY then drops in the same cycle that v[0] & ~adv[0] holds.
- Full + OUT_READY=1: accept and emit in the same cycle; OCC stays N.
- Q and OUT_VALID hold stable while OUT_VALID=1 and OUT_READY=0.
- Reset mid-stream: in-flight words are lost; the first accept after CLR_N rises behaves as from empty.

## Test plan
- Reset: S=12, N=3, hold CLR_N=0 two cycles with IN_VALID=1, D=0xABC. Required: Q=0x000, OUT_VALID=0, OCC=0, and nothing accepted.
- Streaming: send 0x001..0x008 on consecutive cycles with OUT_READY=1. Required: OUT_VALID rises 3 cycles after the first accept; Q emits 0x001..0x008 in order, one per cycle; OCC=3 in steady state.
- Back-pressure:
  - OUT_READY=0, offer 0x010..0x014. Required: IN_READY drops after 3 accepts (0x010..0x012); OCC=3; Q holds 0x010.
  - Raise OUT_READY for 1 cycle. Required: 0x010 consumed, 0x013 accepted the same cycle, OCC stays 3.
- Bubble collapse: accept 0x021, idle 2 cycles, accept 0x022, with OUT_READY=0. Required: both words packed in stages 2 and 1, OCC=2, IN_READY=1.
- Flush: pipe holding 3 words, assert FLUSH with IN_VALID=1, D=0x0FF. Required: next cycle OCC=0, OUT_VALID=0, and 0x0FF never appears on Q.
- Simultaneous CLR_N=0 and FLUSH=1 mid-stream. Required: reset behaviour (Q=0); OCC matches popcount of valid stages throughout a random 1000-cycle run.
